// File: rtl/rv_defs.sv
// Shared definitions for the instruction-memory responder: NOP encoding, default depth
// and loader state encoding.
package rv_defs;
  localparam int          IMEM_DEPTH_LOG2 = 8;
  localparam logic [31:0] IMEM_NOP_INSTR  = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ld_state_t;
endpackage

// File: rtl/imem_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; a last byte flushes a partial word
// with its unfilled upper lanes zeroed.
module imem_byte_packer
  import rv_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  input  logic        byte_last,
  output logic        word_wr,
  output logic [31:0] word_data
);
  logic [1:0] byte_cnt_reg;
  logic [7:0] lane_reg [3];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      byte_cnt_reg <= 2'd0;
    end else if (byte_en) begin
      byte_cnt_reg <= byte_last ? 2'd0 : byte_cnt_reg + 2'd1;
    end
  end

  // Lane 3 is never stored: the word is written in the cycle its fourth byte arrives.
  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    always_ff @(posedge clk) begin
      if (byte_en && byte_cnt_reg == 2'(gi)) lane_reg[gi] <= byte_data;
    end
    assign word_data[8*gi +: 8] = (byte_cnt_reg == 2'(gi)) ? byte_data :
                                  (byte_cnt_reg >  2'(gi)) ? lane_reg[gi] : 8'h00;
  end

  assign word_data[31:24] = (byte_cnt_reg == 2'd3) ? byte_data : 8'h00;
  assign word_wr          = byte_en && (byte_cnt_reg == 2'd3 || byte_last);
endmodule

// File: rtl/imem_responder.sv
// Instruction RAM with a 1-cycle registered fetch port and a byte-serial run-time loader
// that stalls the fetch stage while it owns the RAM.
module imem_responder
  import rv_defs::*;
#(
  parameter int          DEPTH_LOG2 = IMEM_DEPTH_LOG2,
  parameter logic [31:0] NOP_INSTR  = IMEM_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic        fetch_fault,
  output logic        fetch_stall,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        ld_done,
  output logic        ld_error
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]         mem [DEPTH];
  logic [31:0]         ram_q_reg;
  ld_state_t           state_reg;
  logic [DEPTH_LOG2:0] word_addr_reg;
  logic                fetch_valid_reg, nop_sel_reg, fetch_stall_reg;
  logic                ld_ready_reg, ld_done_reg, ld_error_reg;

  logic        in_load, fetch_en, fetch_bad, ld_accept, packer_clear;
  logic        word_wr, ram_we;
  logic [31:0] word_data;

  assign in_load      = (state_reg == ST_LOAD);
  assign fetch_en     = (state_reg == ST_RUN) && fetch_req;
  assign fetch_bad    = (fetch_addr[1:0] != 2'b00) || (fetch_addr[31:DEPTH_LOG2+2] != '0);
  // A restart takes priority; a byte offered in the same cycle is discarded.
  assign ld_accept    = in_load && ld_valid && ld_ready_reg && !ld_start;
  assign packer_clear = ld_start && (state_reg != ST_DONE);
  assign ram_we       = word_wr && !word_addr_reg[DEPTH_LOG2] && !reset;

  imem_byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (packer_clear),
    .byte_en   (ld_accept),
    .byte_data (ld_data),
    .byte_last (ld_last),
    .word_wr   (word_wr),
    .word_data (word_data)
  );

  always_ff @(posedge clk) begin
    if (ram_we) mem[word_addr_reg[DEPTH_LOG2-1:0]] <= word_data;
    if (fetch_en) ram_q_reg <= mem[fetch_addr[DEPTH_LOG2+1:2]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_RUN;
      word_addr_reg   <= '0;
      fetch_valid_reg <= 1'b0;
      nop_sel_reg     <= 1'b1;
      fetch_stall_reg <= 1'b0;
      ld_ready_reg    <= 1'b0;
      ld_done_reg     <= 1'b0;
      ld_error_reg    <= 1'b0;
    end else begin
      fetch_valid_reg <= 1'b0;
      ld_done_reg     <= 1'b0;
      case (state_reg)
        ST_RUN: begin
          if (fetch_req) begin
            fetch_valid_reg <= 1'b1;
            nop_sel_reg     <= fetch_bad;
          end
          if (ld_start) begin
            state_reg       <= ST_LOAD;
            word_addr_reg   <= '0;
            ld_error_reg    <= 1'b0;
            fetch_stall_reg <= 1'b1;
            ld_ready_reg    <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (ld_start) begin
            word_addr_reg <= '0;
            ld_error_reg  <= 1'b0;
          end else begin
            // Past the end of RAM the address saturates and bytes just drain.
            if (word_wr) begin
              if (word_addr_reg[DEPTH_LOG2]) ld_error_reg  <= 1'b1;
              else                           word_addr_reg <= word_addr_reg + 1'b1;
            end
            if (ld_accept && ld_last) begin
              state_reg    <= ST_DONE;
              ld_ready_reg <= 1'b0;
              ld_done_reg  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_reg       <= ST_RUN;
          fetch_stall_reg <= 1'b0;
        end
        default: begin
          state_reg       <= ST_RUN;
          fetch_stall_reg <= 1'b0;
          ld_ready_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_valid = fetch_valid_reg;
  assign fetch_instr = nop_sel_reg ? NOP_INSTR : ram_q_reg;
  assign fetch_fault = fetch_valid_reg && nop_sel_reg;
  assign fetch_stall = fetch_stall_reg;
  assign ld_ready    = ld_ready_reg;
  assign ld_done     = ld_done_reg;
  assign ld_error    = ld_error_reg;
endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: a byte-level loader model predicts RAM contents and
// every fetch response is checked against it in order.
module tb_imem_responder;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_valid, fetch_fault, fetch_stall;
  logic [31:0] fetch_instr;
  logic        ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
  logic [7:0]  ld_data = '0;
  logic        ld_ready, ld_done, ld_error;

  imem_responder dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
    .fetch_fault(fetch_fault), .fetch_stall(fetch_stall),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .ld_done(ld_done), .ld_error(ld_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model of RAM and loader
  logic [31:0] model_mem [256];
  int          m_widx;
  int          m_bcnt;
  logic [31:0] m_word;
  bit          m_err;

  typedef struct { logic [31:0] addr; logic [31:0] instr; logic fault; } exp_t;
  exp_t sb_q[$];
  logic [7:0]  tx_bytes[$];
  logic [31:0] fetch_addrs[$];
  int          done_cnt = 0;
  logic        req_d = 1'b0;

  task automatic model_start();
    m_widx = 0; m_bcnt = 0; m_word = '0; m_err = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit last);
    m_word[8*m_bcnt +: 8] = b;
    if (m_bcnt == 3 || last) begin
      if (m_widx < 256) model_mem[m_widx] = m_word;
      else              m_err = 1'b1;
      m_widx++;
      m_word = '0;
      m_bcnt = 0;
    end else begin
      m_bcnt++;
    end
  endtask

  task automatic push_fetch(input logic [31:0] a);
    exp_t e;
    e.addr = a;
    if (a[1:0] != 2'b00 || a[31:10] != '0) begin
      e.instr = NOP; e.fault = 1'b1;
    end else begin
      e.instr = model_mem[a[9:2]]; e.fault = 1'b0;
    end
    sb_q.push_back(e);
  endtask

  always @(posedge clk) req_d <= !reset && fetch_req && !fetch_stall;

  always @(negedge clk) begin
    if (ld_done) done_cnt++;
    if (fetch_valid !== req_d) check("fetch_valid_timing", {31'd0, fetch_valid}, {31'd0, req_d});
    if (fetch_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("fetch addr=%h instr=%h fault=%0b (exp %h/%0b)",
                 e.addr, fetch_instr, fetch_fault, e.instr, e.fault);
        check("fetch_instr", fetch_instr, e.instr);
        check("fetch_fault", {31'd0, fetch_fault}, {31'd0, e.fault});
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; ld_valid = 1'b0; ld_start = 1'b0; fetch_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic start_load(input bit with_fetch, input logic [31:0] a);
    @(negedge clk);
    ld_start = 1'b1;
    if (with_fetch) begin
      fetch_req = 1'b1; fetch_addr = a; push_fetch(a);
    end
    model_start();
    @(negedge clk);
    ld_start = 1'b0; fetch_req = 1'b0;
  endtask

  task automatic send_bytes(input bit with_last);
    int n;
    n = tx_bytes.size();
    for (int i = 0; i < n; i++) begin
      int t = 0;
      @(negedge clk);
      while (!ld_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      check("ld_ready", {31'd0, ld_ready}, 32'd1);
      ld_valid = 1'b1;
      ld_data  = tx_bytes[i];
      ld_last  = with_last && (i == n - 1);
      model_byte(tx_bytes[i], with_last && (i == n - 1));
    end
    @(negedge clk);
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic expect_done(input int done_before, input string tag);
    repeat (2) @(negedge clk);
    $display("load %s complete: done pulses=%0d ld_error=%0b", tag, done_cnt - done_before, ld_error);
    check({tag, "_done_once"}, 32'(done_cnt - done_before), 32'd1);
    check({tag, "_stall_low"}, {31'd0, fetch_stall}, 32'd0);
    check({tag, "_ready_low"}, {31'd0, ld_ready}, 32'd0);
    check({tag, "_error"},     {31'd0, ld_error}, {31'd0, m_err});
  endtask

  task automatic fetch_seq();
    for (int i = 0; i < fetch_addrs.size(); i++) begin
      @(negedge clk);
      fetch_req = 1'b1; fetch_addr = fetch_addrs[i];
      push_fetch(fetch_addrs[i]);
    end
    @(negedge clk);
    fetch_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    do_reset();
    @(negedge clk);
    check("rst_valid", {31'd0, fetch_valid}, 32'd0);
    check("rst_instr", fetch_instr, NOP);
    check("rst_fault", {31'd0, fetch_fault}, 32'd0);
    check("rst_stall", {31'd0, fetch_stall}, 32'd0);
    check("rst_ready", {31'd0, ld_ready}, 32'd0);
    check("rst_done",  {31'd0, ld_done}, 32'd0);
    check("rst_error", {31'd0, ld_error}, 32'd0);

    // 1: two-word program
    d0 = done_cnt;
    start_load(1'b0, 32'h0);
    check("stall_first_load_cycle", {31'd0, fetch_stall}, 32'd1);
    tx_bytes = {8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_bytes(1'b1);
    expect_done(d0, "t1");

    // 2: back-to-back fetches; 3: faulting addresses
    fetch_addrs = {32'h0, 32'h4};
    fetch_seq();
    fetch_addrs = {32'h2, 32'h400, 32'h8000_0000, 32'h4};
    fetch_seq();

    // 4: partial final word, load started in the same cycle as a fetch
    d0 = done_cnt;
    start_load(1'b1, 32'h4);
    tx_bytes = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    send_bytes(1'b1);
    expect_done(d0, "t4");
    fetch_addrs = {32'h0, 32'h4};
    fetch_seq();

    // 5: overflow, 257 words into a 256-word RAM
    d0 = done_cnt;
    start_load(1'b0, 32'h0);
    tx_bytes = {};
    for (int i = 0; i < 1028; i++) tx_bytes.push_back(8'(i * 7 + 3));
    send_bytes(1'b1);
    expect_done(d0, "t5");
    fetch_addrs = {32'h0, 32'h3FC, 32'h200, 32'h4};
    fetch_seq();
    check("t5_error_sticky", {31'd0, ld_error}, 32'd1);

    // 6: reset mid-load keeps the completed word
    start_load(1'b0, 32'h0);
    tx_bytes = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_bytes(1'b0);
    do_reset();
    @(negedge clk);
    check("t6_error_clr", {31'd0, ld_error}, 32'd0);
    check("t6_stall_clr", {31'd0, fetch_stall}, 32'd0);
    fetch_addrs = {32'h0, 32'h4};
    fetch_seq();

    // restart mid-load rewrites from word 0
    d0 = done_cnt;
    start_load(1'b0, 32'h0);
    tx_bytes = {8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    send_bytes(1'b0);
    start_load(1'b0, 32'h0);
    tx_bytes = {8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_bytes(1'b1);
    expect_done(d0, "t6r");
    fetch_addrs = {32'h0, 32'h4, 32'h8};
    fetch_seq();

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
